// File: rtl/lake_harness_pkg.sv
// Shared types and default sizes for the lake port traffic harness.
// Imported by the harness top and its capture memory.
package lake_harness_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } harness_state_t;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_NUM_WR        = 4;
    localparam int DEF_NUM_RD        = 4;
    localparam int DEF_CNT_WIDTH     = 16;
    localparam int DEF_CAPTURE_DEPTH = 256;
    localparam int DEF_DELAY_WIDTH   = 8;

endpackage

// File: rtl/lake_harness_capture_mem.sv
// Per-read-channel capture banks: one write port per bank,
// a shared registered readback port muxed by channel select.
module lake_harness_capture_mem
    import lake_harness_pkg::*;
#(
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int DEPTH      = DEF_CAPTURE_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD-1:0]                wr_en,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [NUM_RD*DATA_WIDTH-1:0]     wr_data,
    input  logic [$clog2(NUM_RD)-1:0]        rd_sel,
    input  logic [$clog2(DEPTH)-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [NUM_RD*DATA_WIDTH-1:0] bank_flat;
    logic [$clog2(NUM_RD)-1:0]    sel_q;

    for (genvar j = 0; j < NUM_RD; j++) begin : g_bank
        logic [DATA_WIDTH-1:0] ram [DEPTH];
        logic [DATA_WIDTH-1:0] q;

        always_ff @(posedge clk) begin
            if (wr_en[j])
                ram[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            q <= ram[rd_addr];
        end

        assign bank_flat[j*DATA_WIDTH +: DATA_WIDTH] = q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sel_q <= '0;
        else
            sel_q <= rd_sel;
    end

    assign rd_data = bank_flat[32'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/lake_port_traffic_harness.sv
// Stream stimulus/capture engine: valid/ready writers, delayed-ready readers,
// run FSM with completion, post-completion valid and timeout checks.
module lake_port_traffic_harness
    import lake_harness_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_WR        = DEF_NUM_WR,
    parameter int NUM_RD        = DEF_NUM_RD,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int CAPTURE_DEPTH = DEF_CAPTURE_DEPTH,
    parameter int DELAY_WIDTH   = DEF_DELAY_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               start,
    input  logic                               cfg_static,
    input  logic [DATA_WIDTH-1:0]              cfg_stride,
    input  logic [31:0]                        cfg_timeout,
    input  logic [NUM_WR*CNT_WIDTH-1:0]        cfg_wr_num,
    input  logic [NUM_RD*CNT_WIDTH-1:0]        cfg_rd_num,
    input  logic [NUM_RD*DELAY_WIDTH-1:0]      cfg_rd_delay,
    output logic [NUM_WR*DATA_WIDTH-1:0]       wr_data,
    output logic [NUM_WR-1:0]                  wr_valid,
    input  logic [NUM_WR-1:0]                  wr_ready,
    input  logic [NUM_RD*DATA_WIDTH-1:0]       rd_data,
    input  logic [NUM_RD-1:0]                  rd_valid,
    output logic [NUM_RD-1:0]                  rd_ready,
    input  logic [$clog2(NUM_RD)-1:0]          cap_sel,
    input  logic [$clog2(CAPTURE_DEPTH)-1:0]   cap_addr,
    output logic [DATA_WIDTH-1:0]              cap_data,
    output logic [63:0]                        cycle_count,
    output logic                               done,
    output logic                               pass,
    output logic [NUM_RD-1:0]                  err_extra,
    output logic                               err_timeout
);
    localparam int AW = $clog2(CAPTURE_DEPTH);

    harness_state_t state;

    logic run;
    logic in_done;
    logic launch;
    logic all_done;
    logic timeout_hit;
    logic clr;

    logic [NUM_WR-1:0]    wr_done;
    logic [NUM_RD-1:0]    rd_done;
    logic [NUM_RD-1:0]    cap_we;
    logic [NUM_RD*AW-1:0] cap_waddr;

    assign run      = (state == RUN);
    assign in_done  = (state == DONE);
    assign launch   = start & ~run;
    assign clr      = flush | launch;
    assign all_done = (&wr_done) & (&rd_done);

    assign timeout_hit = (cfg_timeout != 32'd0) &&
                         (cycle_count == {32'd0, cfg_timeout} - 64'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (all_done || timeout_hit) state <= DONE;
                DONE:    if (start) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cycle_count <= '0;
        else if (clr)
            cycle_count <= '0;
        else if (run && cycle_count != '1)
            cycle_count <= cycle_count + 64'd1;
    end

    // Completion in the same cycle as the limit is a clean finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_timeout <= 1'b0;
        else if (clr)
            err_timeout <= 1'b0;
        else if (run && timeout_hit && !all_done)
            err_timeout <= 1'b1;
    end

    assign done = in_done;
    assign pass = in_done & ~(|err_extra) & ~err_timeout;

    for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
        logic [CNT_WIDTH-1:0] num;
        logic [CNT_WIDTH-1:0] cnt;

        assign num         = cfg_wr_num[i*CNT_WIDTH +: CNT_WIDTH];
        assign wr_valid[i] = run && (cnt < num);
        assign wr_done[i]  = (cnt == num);

        assign wr_data[i*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(cnt) * cfg_stride;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (clr)
                cnt <= '0;
            else if (wr_valid[i] && wr_ready[i])
                cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [CNT_WIDTH-1:0]   num;
        logic [CNT_WIDTH-1:0]   cnt;
        logic [DELAY_WIDTH-1:0] dly;
        logic                   hs;
        logic                   err;

        assign num = cfg_rd_num[j*CNT_WIDTH +: CNT_WIDTH];
        assign dly = cfg_rd_delay[j*DELAY_WIDTH +: DELAY_WIDTH];

        assign rd_ready[j] = run && (cycle_count >= 64'(dly)) && (cnt < num);
        assign hs          = rd_valid[j] & rd_ready[j];
        assign rd_done[j]  = (cnt == num);
        assign err_extra[j] = err;

        // Samples beyond the buffer are counted but not stored.
        assign cap_we[j] = hs && (64'(cnt) < 64'(CAPTURE_DEPTH));
        assign cap_waddr[j*AW +: AW] = AW'(cnt);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (clr)
                cnt <= '0;
            else if (hs)
                cnt <= cnt + CNT_WIDTH'(1);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                err <= 1'b0;
            else if (clr)
                err <= 1'b0;
            else if (!cfg_static && (run || in_done) && rd_valid[j] && cnt == num)
                err <= 1'b1;
        end
    end

    lake_harness_capture_mem #(
        .NUM_RD     (NUM_RD),
        .DEPTH      (CAPTURE_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cap (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cap_we),
        .wr_addr (cap_waddr),
        .wr_data (rd_data),
        .rd_sel  (cap_sel),
        .rd_addr (cap_addr),
        .rd_data (cap_data)
    );

endmodule
